// File: rtl/c17_pipe_array.sv
// Three-stage pipelined array of ISCAS c17 circuits, one NAND level per stage.
// Optional accepted-result counter on out_count when C17_PIPE_CNT_EN is defined.
module c17_pipe_array #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] in_n1,
  input  logic [LANES-1:0] in_n2,
  input  logic [LANES-1:0] in_n3,
  input  logic [LANES-1:0] in_n6,
  input  logic [LANES-1:0] in_n7,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LANES-1:0] out_n22,
  output logic [LANES-1:0] out_n23,
  output logic             out_valid,
  input  logic             out_ready
`ifdef C17_PIPE_CNT_EN
  ,
  output logic [CNT_W-1:0] out_count
`endif
);

  typedef struct packed {
    logic [LANES-1:0] n10;
    logic [LANES-1:0] n11;
    logic [LANES-1:0] n2;
    logic [LANES-1:0] n7;
  } s1_t;

  typedef struct packed {
    logic [LANES-1:0] n10;
    logic [LANES-1:0] n16;
    logic [LANES-1:0] n19;
  } s2_t;

  logic v1, v2, v3;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic [LANES-1:0] n22_d, n23_d;
  logic adv1, adv2, adv3, acc;

  // A stage moves on when its successor is empty or moving itself
  assign adv3     = v3 && out_ready;
  assign adv2     = v2 && (!v3 || adv3);
  assign adv1     = v1 && (!v2 || adv2);
  assign in_ready = !v1 || adv1;
  assign acc      = in_valid && in_ready;

  always_comb begin
    s1_d.n10 = ~(in_n1 & in_n3);
    s1_d.n11 = ~(in_n3 & in_n6);
    s1_d.n2  = in_n2;
    s1_d.n7  = in_n7;
    s2_d.n10 = s1_q.n10;
    s2_d.n16 = ~(s1_q.n2 & s1_q.n11);
    s2_d.n19 = ~(s1_q.n11 & s1_q.n7);
    n22_d    = ~(s2_q.n10 & s2_q.n16);
    n23_d    = ~(s2_q.n16 & s2_q.n19);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (acc)       v1 <= 1'b1;
      else if (adv1) v1 <= 1'b0;
      if (adv1)      v2 <= 1'b1;
      else if (adv2) v2 <= 1'b0;
      if (adv2)      v3 <= 1'b1;
      else if (adv3) v3 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      out_n22 <= '0;
      out_n23 <= '0;
    end else begin
      if (acc)  s1_q <= s1_d;
      if (adv1) s2_q <= s2_d;
      if (adv2) begin
        out_n22 <= n22_d;
        out_n23 <= n23_d;
      end
    end
  end

  assign out_valid = v3;

`ifdef C17_PIPE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      out_count <= '0;
    else if (adv3 && (out_count != {CNT_W{1'b1}}))
      out_count <= out_count + 1'b1;
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: doc/c17_pipe_array.md
C17_PIPE_ARRAY -- requirements
Module: c17_pipe_array

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent c17 lanes, legal range 1..64.
REQ-002 SHALL have parameter CNT_W, default 16: width of out_count, legal range 4..32.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports in_n1, in_n2, in_n3, in_n6, in_n7  input  LANES each  lane i uses bit i of every input.
REQ-006 SHALL have port in_valid  input  1  input vector presented.
REQ-007 SHALL have port in_ready  output  1  stage 1 can accept this cycle.
REQ-008 SHALL have ports out_n22, out_n23  output  LANES each  per-lane c17 results.
REQ-009 SHALL have port out_valid  output  1  stage 3 holds a result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port out_count  output  CNT_W  number of accepted results, present only under C17_PIPE_CNT_EN.

Function
REQ-012 SHALL compute per lane: N10=NAND(N1,N3), N11=NAND(N3,N6), N16=NAND(N2,N11), N19=NAND(N11,N7), N22=NAND(N10,N16), N23=NAND(N16,N19).
REQ-013 SHALL register each NAND level in its own stage: stage 1 holds {N10,N11,N2,N7}, stage 2 holds {N10,N16,N19}, stage 3 holds {N22,N23}.
REQ-014 SHALL give each stage a valid bit; out_valid SHALL be the stage-3 valid bit.
REQ-015 SHALL accept input when in_valid && in_ready, and SHALL drain output when out_valid && out_ready.
REQ-016 SHALL advance stage k when stage k+1 is empty or advancing (bubble collapse); stage 3 SHALL advance only on drain.
REQ-017 SHALL derive in_ready combinationally: in_ready = !stage1_valid || stage1_advances; in_ready SHALL NOT depend on in_valid.
REQ-018 SHALL, with out_ready held high, present the result of an accepted vector exactly 3 cycles after acceptance and sustain 1 vector per cycle.
REQ-019 SHALL, while out_valid && !out_ready, hold out_n22, out_n23 and out_valid stable.
REQ-020 SHALL hold up to 3 vectors in flight; when all 3 stages are full and out_ready=0, in_ready SHALL be 0.
REQ-021 SHALL, when full with simultaneous drain and accept, shift all stages in the same cycle and keep in_ready=1 with no loss or duplication.
REQ-022 SHALL NOT create stage-1 contents when in_valid=0; stages not advancing SHALL keep their data.
REQ-023 SHALL keep lanes fully independent; no lane SHALL affect another lane's result.

Reset
REQ-024 SHALL, while rst_n=0 at a clock edge, clear all valid bits, stage data, out_n22, out_n23 and out_count to 0.
REQ-025 SHALL drive in_ready=1 and out_valid=0 in the first cycle after reset is released.
REQ-026 SHALL discard all in-flight vectors when reset is asserted mid-operation; none SHALL reappear after release.

Configuration
REQ-027 SHALL, when macro C17_PIPE_CNT_EN is defined, provide out_count, incremented by 1 on each drain and saturating at 2^CNT_W-1.
REQ-028 SHALL, when C17_PIPE_CNT_EN is undefined, omit out_count and its counter; all other behaviour SHALL be identical.

Verification
REQ-029 SHALL verify LANES=4, rst_n low 2 cycles, then release -> out_valid=0, in_ready=1, out_n22=out_n23=4'b0000.
REQ-030 SHALL verify single vector: lanes {N1,N2,N3,N6,N7} = lane0 10101, lane1 01010, lane2 00000, lane3 11111, out_ready=1 -> 3 cycles later out_valid=1, out_n22=4'b1011, out_n23=4'b0011 (bit3..bit0).
REQ-031 SHALL verify streaming: 10 back-to-back vectors with out_ready=1 -> 10 consecutive out_valid cycles, in order, in_ready constantly 1.
REQ-032 SHALL verify backpressure: out_ready=0 while 5 vectors are offered -> exactly 3 accepted, in_ready=0, output frozen; out_ready=1 -> remaining 2 accepted and all 5 delivered in order.
REQ-033 SHALL verify mid-operation reset: rst_n low for 1 cycle with 2 vectors in flight -> no out_valid afterwards until a new vector is accepted.
REQ-034 SHALL verify, with C17_PIPE_CNT_EN and CNT_W=4, 20 drained results -> out_count=4'hF (saturated).
